// File: rtl/display_scroll_ctrl.sv
// display_scroll_ctrl: steps a 16-character message through a four-digit window.
//   The window advances on button presses in manual mode or on a timer in auto mode.
//   The button also pauses and resumes the auto-scroll timer.
// Ports:
//   clk, reset_sync (async, active-high)       clock and reset
//   btn_pulse, auto_en                         step/pause button and mode select
//   load_valid/load_ready, load_addr/load_data character buffer write handshake
//   char3..char0, win_ptr                      visible characters (left to right) and window pointer
//   step_pulse, scroll_state                   advance strobe and mode (00 MANUAL, 01 AUTO, 10 PAUSED)
module display_scroll_ctrl #(
  parameter int MSG_LEN    = 16,
  parameter int STEP_TICKS = 50_000_000,
  parameter int TICK_W     = 26
) (
  input  logic       clk,
  input  logic       reset_sync,
  input  logic       btn_pulse,
  input  logic       auto_en,
  input  logic       load_valid,
  input  logic [3:0] load_addr,
  input  logic [3:0] load_data,
  output logic       load_ready,
  output logic [3:0] char3,
  output logic [3:0] char2,
  output logic [3:0] char1,
  output logic [3:0] char0,
  output logic [3:0] win_ptr,
  output logic       step_pulse,
  output logic [1:0] scroll_state
);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    PAUSED = 2'b10
  } state_t;

  localparam logic [TICK_W-1:0] STEP_LAST = TICK_W'(STEP_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  state_t            state;
  state_t            state_next;
  logic [TICK_W-1:0] timer;
  logic [TICK_W-1:0] timer_next;
  logic [3:0]        ptr_next;
  logic              advance;
  logic              wr_en;
  logic [3:0]        msg      [MSG_LEN];
  logic [3:0]        msg_next [MSG_LEN];

  // Writes are refused while auto-scrolling; the requester simply holds.
  assign load_ready   = (state != AUTO);
  assign wr_en        = load_valid && load_ready;
  assign scroll_state = state;

  // Buffer contents after this cycle's write, so the char registers see
  // freshly written data in the same edge (write forwarding).
  always_comb begin
    msg_next = msg;
    if (wr_en) begin
      msg_next[load_addr] = load_data;
    end
  end

  // Next-state, timer and advance decision. Dropping auto_en wins over
  // everything else; in AUTO a button press pauses and swallows any
  // coincident timer step.
  always_comb begin
    state_next = state;
    timer_next = timer;
    advance    = 1'b0;
    if (!auto_en) begin
      state_next = MANUAL;
      timer_next = '0;
      advance    = (state == MANUAL) && btn_pulse;
    end else begin
      case (state)
        MANUAL: begin
          state_next = AUTO;
          timer_next = '0;
          advance    = btn_pulse;
        end
        AUTO: begin
          if (btn_pulse) begin
            state_next = PAUSED;
          end else if (timer == STEP_LAST) begin
            timer_next = '0;
            advance    = 1'b1;
          end else begin
            timer_next = timer + TICK_ONE;
          end
        end
        PAUSED: begin
          if (btn_pulse) begin
            state_next = AUTO;
            timer_next = '0;
          end
        end
        default: begin
          state_next = MANUAL;
          timer_next = '0;
        end
      endcase
    end
  end

  // Pointer wraps naturally mod 16 through its 4-bit width.
  assign ptr_next = advance ? (win_ptr + 4'd1) : win_ptr;

  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      state      <= MANUAL;
      timer      <= '0;
      win_ptr    <= 4'd0;
      step_pulse <= 1'b0;
      char3      <= 4'd0;
      char2      <= 4'd1;
      char1      <= 4'd2;
      char0      <= 4'd3;
      for (int i = 0; i < MSG_LEN; i++) begin
        msg[i] <= 4'(i);
      end
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      win_ptr    <= ptr_next;
      step_pulse <= advance;
      msg        <= msg_next;
      char3      <= msg_next[ptr_next];
      char2      <= msg_next[ptr_next + 4'd1];
      char1      <= msg_next[ptr_next + 4'd2];
      char0      <= msg_next[ptr_next + 4'd3];
    end
  end

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Testbench for display_scroll_ctrl with a short auto-step period.
// Ports: none (top-level bench).
module tb_display_scroll_ctrl;

  logic       clk;
  logic       reset_sync;
  logic       btn_pulse;
  logic       auto_en;
  logic       load_valid;
  logic [3:0] load_addr;
  logic [3:0] load_data;
  logic       load_ready;
  logic [3:0] char3, char2, char1, char0;
  logic [3:0] win_ptr;
  logic       step_pulse;
  logic [1:0] scroll_state;

  int n_cmp = 0;
  int n_err = 0;

  display_scroll_ctrl #(
    .MSG_LEN   (16),
    .STEP_TICKS(4),
    .TICK_W    (3)
  ) dut (
    .clk         (clk),
    .reset_sync  (reset_sync),
    .btn_pulse   (btn_pulse),
    .auto_en     (auto_en),
    .load_valid  (load_valid),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .char3       (char3),
    .char2       (char2),
    .char1       (char1),
    .char0       (char0),
    .win_ptr     (win_ptr),
    .step_pulse  (step_pulse),
    .scroll_state(scroll_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_pulse  = 1'b0;
    auto_en    = 1'b0;
    load_valid = 1'b0;
    load_addr  = 4'd0;
    load_data  = 4'd0;
    reset_sync = 1'b1;
    tick();
    reset_sync = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({char3, char2, char1, char0} !== 16'h0123) begin
      n_err++; $display("FAIL reset_chars: got %h want 0123", {char3, char2, char1, char0});
    end
    n_cmp++;
    if (win_ptr !== 4'd0) begin
      n_err++; $display("FAIL reset_ptr: got %0d want 0", win_ptr);
    end
    n_cmp++;
    if ({step_pulse, load_ready, scroll_state} !== 4'b0100) begin
      n_err++; $display("FAIL reset_flags: got %b want 0100", {step_pulse, load_ready, scroll_state});
    end
  endtask

  task automatic test_manual_steps();
    int steps;
    do_reset();
    steps = 0;
    for (int i = 0; i < 3; i++) begin
      btn_pulse = 1'b1;
      tick();
      if (step_pulse === 1'b1) steps++;
      btn_pulse = 1'b0;
      tick();
      if (step_pulse === 1'b1) steps++;
    end
    n_cmp++;
    if (steps !== 3) begin
      n_err++; $display("FAIL manual_step_count: got %0d want 3", steps);
    end
    n_cmp++;
    if ({char3, char2, char1, char0} !== 16'h3456) begin
      n_err++; $display("FAIL manual_chars: got %h want 3456", {char3, char2, char1, char0});
    end
    n_cmp++;
    if (win_ptr !== 4'd3) begin
      n_err++; $display("FAIL manual_ptr: got %0d want 3", win_ptr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      btn_pulse = 1'b1;
      tick();
      btn_pulse = 1'b0;
      if (i == 14) begin
        n_cmp++;
        if ({char3, char2, char1, char0} !== 16'hEF01) begin
          n_err++; $display("FAIL wrap_chars14: got %h want EF01", {char3, char2, char1, char0});
        end
      end
      tick();
    end
    n_cmp++;
    if (win_ptr !== 4'd0 || {char3, char2, char1, char0} !== 16'h0123) begin
      n_err++; $display("FAIL wrap_ptr16: got ptr %0d chars %h want ptr 0 chars 0123",
                        win_ptr, {char3, char2, char1, char0});
    end
  endtask

  task automatic test_auto_pause();
    int steps;
    do_reset();
    auto_en = 1'b1;
    tick();
    n_cmp++;
    if (scroll_state !== 2'b01 || load_ready !== 1'b0) begin
      n_err++; $display("FAIL auto_enter: got state %b ready %b want 01 0", scroll_state, load_ready);
    end
    for (int r = 1; r <= 2; r++) begin
      for (int i = 1; i <= 4; i++) begin
        tick();
        n_cmp++;
        if (step_pulse !== (i == 4)) begin
          n_err++; $display("FAIL auto_step_r%0d_t%0d: got %b want %b", r, i, step_pulse, (i == 4));
        end
      end
    end
    n_cmp++;
    if (win_ptr !== 4'd2) begin
      n_err++; $display("FAIL auto_ptr: got %0d want 2", win_ptr);
    end
    btn_pulse = 1'b1;
    tick();
    btn_pulse = 1'b0;
    n_cmp++;
    if (scroll_state !== 2'b10 || load_ready !== 1'b1) begin
      n_err++; $display("FAIL pause_enter: got state %b ready %b want 10 1", scroll_state, load_ready);
    end
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step_pulse !== 1'b0) steps++;
    end
    n_cmp++;
    if (steps !== 0 || win_ptr !== 4'd2) begin
      n_err++; $display("FAIL pause_hold: got steps %0d ptr %0d want 0 2", steps, win_ptr);
    end
    btn_pulse = 1'b1;
    tick();
    btn_pulse = 1'b0;
    n_cmp++;
    if (scroll_state !== 2'b01) begin
      n_err++; $display("FAIL resume_state: got %b want 01", scroll_state);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if (step_pulse !== (i == 4)) begin
        n_err++; $display("FAIL resume_step_t%0d: got %b want %b", i, step_pulse, (i == 4));
      end
    end
    // Press exactly when the timer would expire: pause wins, no step.
    for (int i = 0; i < 3; i++) tick();
    btn_pulse = 1'b1;
    tick();
    btn_pulse = 1'b0;
    n_cmp++;
    if (step_pulse !== 1'b0 || win_ptr !== 4'd3 || scroll_state !== 2'b10) begin
      n_err++; $display("FAIL pause_suppress: got step %b ptr %0d state %b want 0 3 10",
                        step_pulse, win_ptr, scroll_state);
    end
  endtask

  task automatic test_load_in_auto();
    do_reset();
    auto_en = 1'b1;
    tick();
    load_valid = 1'b1;
    load_addr  = 4'd2;
    load_data  = 4'hA;
    tick();
    tick();
    n_cmp++;
    if (load_ready !== 1'b0 || char1 !== 4'd2) begin
      n_err++; $display("FAIL auto_load_blocked: got ready %b char1 %h want 0 2", load_ready, char1);
    end
    auto_en = 1'b0;
    tick();
    n_cmp++;
    if (load_ready !== 1'b1 || char1 !== 4'd2 || scroll_state !== 2'b00) begin
      n_err++; $display("FAIL auto_to_manual: got ready %b char1 %h state %b want 1 2 00",
                        load_ready, char1, scroll_state);
    end
    tick();
    load_valid = 1'b0;
    n_cmp++;
    if ({char3, char2, char1, char0} !== 16'h01A3) begin
      n_err++; $display("FAIL manual_load: got %h want 01A3", {char3, char2, char1, char0});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    btn_pulse  = 1'b1;
    load_valid = 1'b1;
    load_addr  = 4'd4;
    load_data  = 4'd9;
    tick();
    btn_pulse  = 1'b0;
    load_valid = 1'b0;
    n_cmp++;
    if ({char3, char2, char1, char0} !== 16'h1239 || win_ptr !== 4'd1 || step_pulse !== 1'b1) begin
      n_err++; $display("FAIL write_and_step: got chars %h ptr %0d step %b want 1239 1 1",
                        {char3, char2, char1, char0}, win_ptr, step_pulse);
    end
    // Visible write without an advance.
    load_valid = 1'b1;
    load_addr  = 4'd2;
    load_data  = 4'd7;
    tick();
    load_valid = 1'b0;
    n_cmp++;
    if ({char3, char2, char1, char0} !== 16'h1739 || step_pulse !== 1'b0) begin
      n_err++; $display("FAIL write_visible: got chars %h step %b want 1739 0",
                        {char3, char2, char1, char0}, step_pulse);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    auto_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (win_ptr !== 4'd1) begin
      n_err++; $display("FAIL pre_reset_ptr: got %0d want 1", win_ptr);
    end
    #2;
    reset_sync = 1'b1;
    #1;
    n_cmp++;
    if ({char3, char2, char1, char0} !== 16'h0123 || win_ptr !== 4'd0 ||
        scroll_state !== 2'b00 || load_ready !== 1'b1 || step_pulse !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got chars %h ptr %0d state %b ready %b step %b want 0123 0 00 1 0",
                        {char3, char2, char1, char0}, win_ptr, scroll_state, load_ready, step_pulse);
    end
    auto_en = 1'b0;
    tick();
    reset_sync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual_steps();
    test_wrap();
    test_auto_pause();
    test_load_in_auto();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
